// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for fetch_queue.
// The queue uses the slave modport; the fetch/decode environment uses master.
interface fetch_queue_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// IF->ID decoupling queue: DEPTH-entry circular buffer of (pc, inst) pairs with
// independent valid/ready handshakes, global enable, flush and held-PC-when-empty.
module fetch_queue_chk #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input logic                       clk,
    input logic                       rst,
    input logic                       en,
    input logic                       flush,
    input logic                       in_valid,
    input logic                       in_ready,
    input logic [PC_W-1:0]            in_pc,
    input logic [INST_W-1:0]          in_inst,
    input logic [$clog2(DEPTH):0]     count
);
    localparam logic [$clog2(DEPTH):0] MAX_CNT = ($clog2(DEPTH)+1)'(DEPTH);

    a_count_bound : assert property (@(posedge clk) disable iff (!rst)
        count <= MAX_CNT);

    // A refused entry must be held; a flush or a frozen cycle lets fetch re-steer.
    a_in_hold : assert property (@(posedge clk) disable iff (!rst)
        (en && in_valid && !in_ready && !flush) |=>
        (!en || flush || (in_valid && $stable(in_pc) && $stable(in_inst))));
endmodule

module fetch_queue #(
    parameter int                PC_W     = 64,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [PC_W-1:0]   RESET_PC = 64'h80200000,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input logic         clk,
    input logic         rst,
    input logic         en,
    input logic         flush,
    fetch_queue_if.slave q
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [PC_W-1:0]   r_last_pc;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic [PC_W-1:0]   w_out_pc;
    logic [INST_W-1:0] w_out_inst;

    // Handshake qualifiers and head/held-PC output selection from registered state only.
    always_comb begin
        w_in_ready  = (r_count != FULL_CNT);
        w_out_valid = (r_count != {CNT_W{1'b0}});
        w_push      = en & q.in_valid & w_in_ready & ~flush;
        w_pop       = en & w_out_valid & q.out_ready & ~flush;
        if (w_out_valid) begin
            w_out_pc   = r_pc_mem[r_head];
            w_out_inst = r_inst_mem[r_head];
        end else begin
            w_out_pc   = r_last_pc;
            w_out_inst = NOP_INST;
        end
    end

    assign q.in_ready  = w_in_ready;
    assign q.out_valid = w_out_valid;
    assign q.out_pc    = w_out_pc;
    assign q.out_inst  = w_out_inst;
    assign q.count     = r_count;

    // Entry storage; contents are don't-care after reset so no reset branch.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]   <= q.in_pc;
            r_inst_mem[r_tail] <= q.in_inst;
        end
    end

    // Pointer, occupancy and held-PC control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head    <= {PTR_W{1'b0}};
            r_tail    <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_last_pc <= RESET_PC;
        end else if (en) begin
            if (flush) begin
                r_head    <= {PTR_W{1'b0}};
                r_tail    <= {PTR_W{1'b0}};
                r_count   <= {CNT_W{1'b0}};
                r_last_pc <= w_out_pc;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_ONE;
                end
                if (w_pop) begin
                    r_head    <= r_head + PTR_ONE;
                    r_last_pc <= r_pc_mem[r_head];
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    fetch_queue_chk #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .in_valid (q.in_valid),
        .in_ready (w_in_ready),
        .in_pc    (q.in_pc),
        .in_inst  (q.in_inst),
        .count    (r_count)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue plus hand sequences for
// flush, enable freeze and mid-stream reset.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic flush;

    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(64), .INST_W(32), .DEPTH(4)) q ();

    fetch_queue #(
        .PC_W(64), .INST_W(32), .DEPTH(4),
        .RESET_PC(64'h80200000), .NOP_INST(32'h00000013)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .flush (flush),
        .q     (q)
    );

    typedef struct {
        logic        en;
        logic        in_valid;
        logic        out_ready;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        e_ov;
        logic        e_ir;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [63:0] RPC = 64'h80200000;

    function automatic vec_t mk(input logic e, input logic iv, input logic ordy,
                                input logic [63:0] pc, input logic [31:0] inst,
                                input logic ov, input logic ir, input logic [63:0] epc,
                                input logic [31:0] einst, input logic [2:0] ecnt);
        vec_t v;
        v.en = e; v.in_valid = iv; v.out_ready = ordy; v.pc = pc; v.inst = inst;
        v.e_ov = ov; v.e_ir = ir; v.e_pc = epc; v.e_inst = einst; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic ir,
                              input logic [63:0] pc, input logic [31:0] inst,
                              input logic [2:0] cnt);
        chk({tag, ".out_valid"}, 64'(q.out_valid), 64'(ov));
        chk({tag, ".in_ready"},  64'(q.in_ready),  64'(ir));
        chk({tag, ".out_pc"},    q.out_pc,         pc);
        chk({tag, ".out_inst"},  64'(q.out_inst),  64'(inst));
        chk({tag, ".count"},     64'(q.count),     64'(cnt));
    endtask

    task automatic push_one(input logic [63:0] pc, input logic [31:0] inst);
        q.in_valid = 1'b1; q.in_pc = pc; q.in_inst = inst;
        tick();
        q.in_valid = 1'b0;
    endtask

    initial begin
        // Fill to full with decode stalled; fifth push refused, fetch withdraws during a frozen cycle.
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'h1000, 32'hA0, 1'b1, 1'b1, 64'h1000, 32'hA0, 3'd1));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'h1004, 32'hA1, 1'b1, 1'b1, 64'h1000, 32'hA0, 3'd2));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'h1008, 32'hA2, 1'b1, 1'b1, 64'h1000, 32'hA0, 3'd3));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'h100C, 32'hA3, 1'b1, 1'b0, 64'h1000, 32'hA0, 3'd4));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 64'h1010, 32'hA4, 1'b1, 1'b0, 64'h1000, 32'hA0, 3'd4));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 64'h0,    32'h0,  1'b1, 1'b0, 64'h1000, 32'hA0, 3'd4));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 64'h0,    32'h0,  1'b1, 1'b1, 64'h1004, 32'hA1, 3'd3));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 64'h0,    32'h0,  1'b1, 1'b1, 64'h1008, 32'hA2, 3'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 64'h0,    32'h0,  1'b1, 1'b1, 64'h100C, 32'hA3, 3'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 64'h0,    32'h0,  1'b0, 1'b1, 64'h100C, NOP,    3'd0));
        // Streaming push+pop every cycle across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(1'b1, 1'b1, 1'b1, 64'h2000 + 64'(4*i), 32'hB0 + 32'(i),
                             1'b1, 1'b1, 64'h2000 + 64'(4*i), 32'hB0 + 32'(i), 3'd1));
        end
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 64'h0, 32'h0, 1'b0, 1'b1, 64'h2024, NOP, 3'd0));

        rst = 1'b0; en = 1'b1; flush = 1'b0;
        q.in_valid = 1'b0; q.out_ready = 1'b0; q.in_pc = 64'h0; q.in_inst = 32'h0;
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b1, RPC, NOP, 3'd0);
        rst = 1'b1;
        tick();
        check_outs("idle", 1'b0, 1'b1, RPC, NOP, 3'd0);

        foreach (tbl[k]) begin
            en = tbl[k].en; flush = 1'b0;
            q.in_valid = tbl[k].in_valid; q.out_ready = tbl[k].out_ready;
            q.in_pc = tbl[k].pc; q.in_inst = tbl[k].inst;
            tick();
            check_outs($sformatf("vec%0d", k), tbl[k].e_ov, tbl[k].e_ir,
                       tbl[k].e_pc, tbl[k].e_inst, tbl[k].e_cnt);
        end
        en = 1'b1; q.in_valid = 1'b0; q.out_ready = 1'b0;

        // Flush with two pending entries and a same-cycle push that must be dropped.
        push_one(64'h3000, 32'hC0);
        push_one(64'h3004, 32'hC1);
        check_outs("flush_pre", 1'b1, 1'b1, 64'h3000, 32'hC0, 3'd2);
        flush = 1'b1; q.in_valid = 1'b1; q.in_pc = 64'h3008; q.in_inst = 32'hC2;
        tick();
        check_outs("flush", 1'b0, 1'b1, 64'h3000, NOP, 3'd0);
        flush = 1'b0; q.in_valid = 1'b0; q.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_outs($sformatf("flush_post%0d", i), 1'b0, 1'b1, 64'h3000, NOP, 3'd0);
        end
        q.out_ready = 1'b0;

        // Enable freeze: push/pop/flush all requested but ignored.
        push_one(64'h4000, 32'hD0);
        push_one(64'h4004, 32'hD1);
        en = 1'b0; flush = 1'b1; q.in_valid = 1'b1; q.out_ready = 1'b1;
        q.in_pc = 64'h4008; q.in_inst = 32'hD2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("freeze%0d", i), 1'b1, 1'b1, 64'h4000, 32'hD0, 3'd2);
        end
        en = 1'b1; flush = 1'b0; q.in_valid = 1'b0;
        tick();
        check_outs("thaw0", 1'b1, 1'b1, 64'h4004, 32'hD1, 3'd1);
        tick();
        check_outs("thaw1", 1'b0, 1'b1, 64'h4004, NOP, 3'd0);
        q.out_ready = 1'b0;

        // Reset mid-stream with three entries queued.
        push_one(64'h5000, 32'hE0);
        push_one(64'h5004, 32'hE1);
        push_one(64'h5008, 32'hE2);
        check_outs("mid_pre", 1'b1, 1'b1, 64'h5000, 32'hE0, 3'd3);
        rst = 1'b0;
        tick();
        check_outs("mid_rst", 1'b0, 1'b1, RPC, NOP, 3'd0);
        rst = 1'b1; q.out_ready = 1'b1;
        tick();
        check_outs("mid_post", 1'b0, 1'b1, RPC, NOP, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
